uart_rx: RTL and testbench

UART receiver: the downstream consumer of the uart_tx serial line. It recovers framed words (1 start bit, WIDTH data bits LSB first, 1 stop bit, no parity) from an asynchronous serial input. Bits are sampled at mid-bit using the same DIVISOR (clk cycles per bit) as uart_tx. Each received word is presented with a one-cycle valid strobe; a bad stop bit raises a framing-error strobe instead.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing
// constants common to uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // 10 MHz clock, 115200 baud
    localparam int unsigned UART_DIVISOR = 86;
    localparam int unsigned UART_WIDTH   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; INIT is the value
// both flops take during reset.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, WIDTH data bits LSB first, 1 stop, no parity.
// Mid-bit sampling with DIVISOR clk cycles per bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH   = UART_WIDTH,
    parameter int unsigned DIVISOR = UART_DIVISOR
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int unsigned   CW        = $clog2(DIVISOR);
    localparam int unsigned   IW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

    logic             rx_s;
    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shreg;

    sync_2ff #(.INIT(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (i_reset_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        // Shifting in from the MSB leaves the first bit at
                        // bit 0 after WIDTH samples, same as indexed writes.
                        shreg <= {rx_s, shreg[WIDTH-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            o_data <= shreg;
                            o_dv   <= 1'b1;
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Held-low line: one error already flagged, wait for idle.
                    if (rx_s) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand sequences for glitch, reset
// and back-to-back cases, random frames against a queue model, 86/88 loopback.
module tb_uart_rx;

    localparam int BIT = 86;
    localparam int LAT = BIT / 2 + 9 * BIT + 1 + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx88 = 1'b1;
    logic [7:0] data, data88;
    logic       dv, dv88, ferr, ferr88, busy, busy88;

    uart_rx #(.WIDTH(8), .DIVISOR(86)) dut (
        .clk         (clk),
        .i_reset_n   (rst_n),
        .i_rx        (rx),
        .o_data      (data),
        .o_dv        (dv),
        .o_frame_err (ferr),
        .o_busy      (busy)
    );

    uart_rx #(.WIDTH(8), .DIVISOR(88)) dut88 (
        .clk         (clk),
        .i_reset_n   (rst_n),
        .i_rx        (rx88),
        .o_data      (data88),
        .o_dv        (dv88),
        .o_frame_err (ferr88),
        .o_busy      (busy88)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  dv_q[$];
    int unsigned dv_t[$];
    logic [7:0]  dv88_q[$];
    int          err_n = 0, err88_n = 0, both_n = 0, long_n = 0, busy_n = 0;
    logic        pdv = 1'b0, perr = 1'b0;

    always @(negedge clk) begin
        if (dv) begin
            dv_q.push_back(data);
            dv_t.push_back(cyc);
        end
        if (ferr) err_n <= err_n + 1;
        if (dv && ferr) both_n <= both_n + 1;
        if ((dv && pdv) || (ferr && perr)) long_n <= long_n + 1;
        pdv <= dv;
        perr <= ferr;
        if (busy) busy_n <= busy_n + 1;
        if (dv88) dv88_q.push_back(data88);
        if (ferr88) err88_n <= err88_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] qd(input int k);
        if (k < dv_q.size()) return dv_q[k];
        return 8'hxx;
    endfunction

    function automatic int unsigned qt(input int k);
        if (k < dv_t.size()) return dv_t[k];
        return 0;
    endfunction

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx = v;
        else rx88 = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called and returning on a negedge, so consecutive calls abut exactly.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic stopb,
                              output int unsigned t0);
        logic [9:0] bits;
        bits = {stopb, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            set_line(sel, bits[i]);
            hold(BIT);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stopb;
        int         hold_bits;
        int         exp_dv;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t        tbl[6];
    int          n0, e0, b0, exp_err;
    int unsigned t0, tdummy;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_good, wd;
    logic [7:0]  lb_words[8];
    logic        good;
    logic [9:0]  fbits;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 0, 1, 0, 8'hA5};
        tbl[1] = '{8'h55, 1'b0, 3, 0, 1, 8'hA5};
        tbl[2] = '{8'h81, 1'b1, 0, 1, 0, 8'h81};
        tbl[3] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
        tbl[4] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
        tbl[5] = '{8'h3C, 1'b1, 0, 1, 0, 8'h3C};

        hold(3);
        check("reset data", data, 8'h00);
        check("reset dv", dv, 1'b0);
        check("reset ferr", ferr, 1'b0);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        hold(5);

        for (int i = 0; i < 6; i++) begin
            n0 = dv_q.size();
            e0 = err_n;
            send_frame(0, tbl[i].d, tbl[i].stopb, t0);
            hold(tbl[i].hold_bits * BIT);
            rx = 1'b1;
            hold(2 * BIT);
            check($sformatf("vec%0d dv count", i), dv_q.size() - n0, tbl[i].exp_dv);
            check($sformatf("vec%0d ferr count", i), err_n - e0, tbl[i].exp_err);
            check($sformatf("vec%0d o_data", i), data, tbl[i].exp_data);
            if (tbl[i].exp_dv != 0)
                check($sformatf("vec%0d latency", i), qt(n0) - t0, LAT);
        end

        // Short low glitch on the idle line.
        n0 = dv_q.size();
        e0 = err_n;
        b0 = busy_n;
        rx = 1'b0;
        hold(20);
        rx = 1'b1;
        hold(100);
        check("glitch busy window", (busy_n - b0 >= 1) && (busy_n - b0 <= 43), 1);
        check("glitch busy final", busy, 1'b0);
        check("glitch no strobe", (dv_q.size() - n0) + (err_n - e0), 0);

        // Reset in the middle of data bit 4 of 0xF0.
        fbits = {1'b1, 8'hF0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = fbits[i];
            hold(BIT);
        end
        rx = fbits[5];
        hold(BIT / 2);
        n0 = dv_q.size();
        e0 = err_n;
        rst_n = 1'b0;
        #1;
        check("midreset data", data, 8'h00);
        check("midreset dv", dv, 1'b0);
        check("midreset ferr", ferr, 1'b0);
        check("midreset busy", busy, 1'b0);
        hold(5);
        rx = 1'b1;
        rst_n = 1'b1;
        hold(3 * BIT);
        check("midreset no strobe", (dv_q.size() - n0) + (err_n - e0), 0);
        send_frame(0, 8'h0F, 1'b1, t0);
        hold(2 * BIT);
        check("after reset dv count", dv_q.size() - n0, 1);
        check("after reset data", qd(n0), 8'h0F);

        // Back-to-back frames with no idle gap.
        n0 = dv_q.size();
        send_frame(0, 8'h00, 1'b1, tdummy);
        send_frame(0, 8'hFF, 1'b1, tdummy);
        send_frame(0, 8'h3C, 1'b1, tdummy);
        hold(2 * BIT);
        check("b2b count", dv_q.size() - n0, 3);
        check("b2b word0", qd(n0), 8'h00);
        check("b2b word1", qd(n0 + 1), 8'hFF);
        check("b2b word2", qd(n0 + 2), 8'h3C);
        check("b2b gap01", (qt(n0 + 1) - qt(n0) >= 859) && (qt(n0 + 1) - qt(n0) <= 861), 1);
        check("b2b gap12", (qt(n0 + 2) - qt(n0 + 1) >= 859) && (qt(n0 + 2) - qt(n0 + 1) <= 861), 1);

        // Random frames: the model is just the list of frames with a good stop.
        n0 = dv_q.size();
        e0 = err_n;
        exp_err = 0;
        last_good = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            wd = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            send_frame(0, wd, good, tdummy);
            if (good) begin
                exp_q.push_back(wd);
                last_good = wd;
                hold($urandom_range(0, 2) * BIT);
            end else begin
                exp_err++;
                hold($urandom_range(0, 2) * BIT);
                rx = 1'b1;
                hold(BIT * (1 + $urandom_range(0, 1)));
            end
        end
        hold(2 * BIT);
        check("rand dv count", dv_q.size() - n0, exp_q.size());
        check("rand ferr count", err_n - e0, exp_err);
        check("rand o_data", data, last_good);
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("rand word%0d", k), qd(n0 + k), exp_q[k]);

        // Loopback: 86-cycle bits into a receiver dividing by 88.
        n0 = dv88_q.size();
        e0 = err88_n;
        for (int i = 0; i < 8; i++) begin
            lb_words[i] = 8'($urandom_range(0, 255));
            send_frame(1, lb_words[i], 1'b1, tdummy);
        end
        hold(2 * BIT);
        check("loopback count", dv88_q.size() - n0, 8);
        check("loopback ferr", err88_n - e0, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("loopback word%0d", i),
                  (n0 + i < dv88_q.size()) ? dv88_q[n0 + i] : 8'hxx, lb_words[i]);

        check("dv and ferr overlap", both_n, 0);
        check("strobe longer than 1", long_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
